// File: rtl/level_sensor_encoder.sv
`default_nettype none
// =============================================================================
// Module : level_sensor_encoder
// Probe sync/debounce/encode front end with a hysteretic fill-valve FSM.
// Optional build macro: FILL_TIMEOUT_EN (bounds the time spent in FILL).
// Rev    : 1.0
// =============================================================================
module level_sensor_encoder #(
  parameter int DEB_TICKS     = 16,
  parameter int CNT_W         = 8,
  parameter int TIMEOUT_TICKS = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       l_raw_i,
  input  logic       m_raw_i,
  input  logic       h_raw_i,
  input  logic       sample_en_i,
  output logic       l_o,
  output logic       m_o,
  output logic       h_o,
  output logic [1:0] level_o,
  output logic       err_o,
  output logic       vs_o,
  output logic       busy_o
);

  localparam logic [1:0]       ST_IDLE  = 2'd0;
  localparam logic [1:0]       ST_FILL  = 2'd1;
  localparam logic [1:0]       ST_FAULT = 2'd2;
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_TICKS - 1);

  logic [2:0]       meta_q, sync_q;
  logic [2:0]       cand_q, cand_d;
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             done_q, done_d;
  logic             commit_d;
  logic             vec_valid_d;
  logic [1:0]       vec_level_d;
  logic [2:0]       hml_q;
  logic [1:0]       level_q;
  logic             inv_err_q;
  logic             tmo_fault_d;
  logic             err_d;
  logic [1:0]       state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 3'b000;
      sync_q <= 3'b000;
    end else begin
      meta_q <= {h_raw_i, m_raw_i, l_raw_i};
      sync_q <= meta_q;
    end
  end

  // A candidate commits once, on the tick after its count saturates.
  always_comb begin
    cand_d    = cand_q;
    deb_cnt_d = deb_cnt_q;
    done_d    = done_q;
    commit_d  = 1'b0;
    if (sample_en_i) begin
      if (sync_q != cand_q) begin
        cand_d    = sync_q;
        deb_cnt_d = '0;
        done_d    = 1'b0;
      end else if (deb_cnt_q < DEB_LAST) begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end else if (!done_q) begin
        commit_d = 1'b1;
        done_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q    <= 3'b000;
      deb_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      cand_q    <= cand_d;
      deb_cnt_q <= deb_cnt_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    vec_valid_d = 1'b1;
    vec_level_d = 2'b00;
    case (cand_q)
      3'b000:  vec_level_d = 2'b00;
      3'b001:  vec_level_d = 2'b01;
      3'b011:  vec_level_d = 2'b10;
      3'b111:  vec_level_d = 2'b11;
      default: vec_valid_d = 1'b0;
    endcase
  end

  // Invalid vectors flag an error but leave the last valid level in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hml_q     <= 3'b000;
      level_q   <= 2'b00;
      inv_err_q <= 1'b0;
    end else if (commit_d) begin
      if (vec_valid_d) begin
        hml_q     <= cand_q;
        level_q   <= vec_level_d;
        inv_err_q <= 1'b0;
      end else begin
        inv_err_q <= 1'b1;
      end
    end
  end

`ifdef FILL_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_TICKS - 1);

  logic [CNT_W-1:0] tmo_cnt_q;
  logic             tmo_fault_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q   <= '0;
      tmo_fault_q <= 1'b0;
    end else begin
      if (state_q != ST_FILL) begin
        tmo_cnt_q <= '0;
      end else if (sample_en_i && (tmo_cnt_q != TMO_LAST)) begin
        tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end
      // Only a confirmed full tank releases a latched timeout.
      if (commit_d && vec_valid_d && (vec_level_d == 2'b11)) begin
        tmo_fault_q <= 1'b0;
      end else if ((state_q == ST_FILL) && sample_en_i && (tmo_cnt_q == TMO_LAST)) begin
        tmo_fault_q <= 1'b1;
      end
    end
  end

  assign tmo_fault_d = tmo_fault_q;
`else
  assign tmo_fault_d = (TIMEOUT_TICKS < 0);
`endif

  assign err_d = inv_err_q | tmo_fault_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Level only moves on a commit, so evaluating continuously is equivalent.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (err_d)                  state_d = ST_FAULT;
        else if (level_q <= 2'b01)  state_d = ST_FILL;
      end
      ST_FILL: begin
        if (err_d)                  state_d = ST_FAULT;
        else if (level_q == 2'b11)  state_d = ST_IDLE;
      end
      ST_FAULT: begin
        if (!err_d)                 state_d = ST_IDLE;
      end
      default:                      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q == ST_FILL);
    vs_o   = (state_q == ST_FILL) && !err_d;
  end

  assign l_o     = hml_q[0];
  assign m_o     = hml_q[1];
  assign h_o     = hml_q[2];
  assign level_o = level_q;
  assign err_o   = err_d;

endmodule
`default_nettype wire

// File: doc/level_sensor_encoder.md
Name: level_sensor_encoder

Overview:
Sensor-side front end of the irrigation controller. It synchronises and debounces the three raw tank-level probes (low/medium/high) and checks them for consistency. It encodes the committed level into the h/m/l flags and a 2-bit level code consumed by the display decoders. A small FSM drives the fill-valve output vs with hysteresis: fill below medium, stop at high, lock out on probe fault.

Parameters:
DEB_TICKS, 16, consecutive identical sample_en ticks required to commit a new probe vector (range 2..255)
CNT_W, 8, width of debounce and timeout counters
TIMEOUT_TICKS, 200, max sample_en ticks allowed in FILL (used only with FILL_TIMEOUT_EN)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous reset, active-low
l_raw  input  1  raw low probe, asynchronous to clk, 1 = wet
m_raw  input  1  raw medium probe, asynchronous to clk, 1 = wet
h_raw  input  1  raw high probe, asynchronous to clk, 1 = wet
sample_en  input  1  single-cycle sampling tick (debounce/timeout time base)
l  output  1  committed low flag
m  output  1  committed medium flag
h  output  1  committed high flag
level  output  2  committed code: 00 empty, 01 low, 10 medium, 11 high
err  output  1  committed probe vector inconsistent, or timeout fault
vs  output  1  fill valve open
busy  output  1  1 while FSM in FILL

Behaviour:
- Reset: clk and reset are one clock domain; reset asynchronous, active-low. All flops clear: l=m=h=0, level=00, err=0, vs=0, busy=0, FSM=IDLE, counters=0, candidate=000.
- Synchroniser: each raw input passes through 2 flops; sync vector s={h,m,l}.
- Debounce, evaluated only on cycles with sample_en=1:
  - s != candidate: candidate<=s, count<=0.
  - s == candidate and count < DEB_TICKS-1: count++.
  - count reaches DEB_TICKS-1: commit candidate; count saturates and does not re-commit.
  - Min latency, raw edge to outputs: 2 sync cycles + DEB_TICKS sample ticks + 1 clk.
  - sample_en=0: all state holds.
- Consistency check on commit:
  - Valid vectors {h,m,l}: 000, 001, 011, 111. On valid commit: h/m/l/level update and err clears (unless timeout fault is latched).
  - Any other vector: err<=1; h/m/l/level hold the last valid value.
- FSM states IDLE, FILL, FAULT. Transitions are evaluated on the cycle after a commit, or on a timeout:
  - IDLE -> FILL: committed level <= 01 and err=0. Sets vs=1, busy=1.
  - FILL -> IDLE: committed level = 11. Clears vs.
  - Any state -> FAULT: err=1. vs=0 in the same cycle err rises.
  - FAULT -> IDLE: a valid commit clears err. The next cycle re-evaluates the IDLE rule.
- Hysteresis: level=10 in IDLE does not open the valve; level=10 in FILL keeps filling.
- Simultaneous invalid commit and level=11 in FILL: FAULT wins.
- Reset asserted mid-FILL: vs drops immediately (asynchronous).

Optional Feature:
Macro FILL_TIMEOUT_EN.
- Defined: a timeout counter increments on sample_en while in FILL and clears on entering FILL. When it reaches TIMEOUT_TICKS, the FSM goes to FAULT and err=1 (timeout fault latched). The latch clears only on a valid commit showing level=11 or on reset.
- Undefined: no timeout counter is built; TIMEOUT_TICKS is ignored; FILL can last indefinitely.

Test Plan:
- Reset, raw=000 held, DEB_TICKS=4, sample_en every cycle -> after 2+4+1 cycles level=00, vs=1, busy=1.
- Raw steps 000->001->011->111, each held 10 ticks -> level 01, 10, 11 in order; vs stays 1 through 10 and falls within 1 clk of level=11.
- From 111, raw drops to 011 -> level=10, vs stays 0; then to 001 -> vs=1.
- Raw=101 held 10 ticks during FILL -> err=1, vs=0, h/m/l hold 011; then raw=111 -> err=0, FSM IDLE, vs=0.
- Glitch: raw 011 toggles to 111 for DEB_TICKS-1 ticks then back -> no commit; outputs unchanged.
- FILL_TIMEOUT_EN, TIMEOUT_TICKS=20, raw stuck 001 -> after 20 ticks in FILL err=1, vs=0; raw 111 committed -> err=0.
